// File: rtl/bus_cycle_unit.sv
// bus_cycle_unit: 8088-style T1-T2-T3-[Tw]-T4 bus-cycle engine with 20-bit segment:offset addressing.
// Define BCU_WAIT_TIMEOUT_EN to bound consecutive Tw cycles and flag rsp_err on expiry.
module bus_cycle_unit #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16,
    parameter int SEG_SHIFT = 4
`ifdef BCU_WAIT_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 15
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [15:0]       req_seg,
    input  logic [15:0]       req_off,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_ale,
    output logic              bus_rd_wr,
    output logic [DATA_W-1:0] bus_data_out,
    output logic              bus_data_oe,
    input  logic [DATA_W-1:0] bus_data_in,
    input  logic              bus_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    typedef enum logic [2:0] {IDLE, T1, T2, T3, TW, T4} state_t;

    state_t            state;
    logic              op_q;
    logic [DATA_W-1:0] wdata_q;
    logic              accept;
    logic [ADDR_W-1:0] phys_addr;
    logic [DATA_W-1:0] capture_data;

    // Ready is gated by reset so nothing is offered while the unit is held in reset.
    assign req_ready    = reset && ((state == IDLE) || (state == T4));
    assign accept       = req_valid && req_ready;
    assign phys_addr    = (ADDR_W'(req_seg) << SEG_SHIFT) + ADDR_W'(req_off);
    assign capture_data = op_q ? '0 : bus_data_in;

`ifdef BCU_WAIT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;
    logic             wait_expired;

    assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign rsp_err      = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            op_q         <= 1'b0;
            wdata_q      <= '0;
            bus_addr     <= '0;
            bus_ale      <= 1'b0;
            bus_rd_wr    <= 1'b0;
            bus_data_out <= '0;
            bus_data_oe  <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
`ifdef BCU_WAIT_TIMEOUT_EN
            wait_cnt     <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                end
                T1: begin
                    state   <= T2;
                    bus_ale <= 1'b0;
                    if (op_q) begin
                        bus_data_oe  <= 1'b1;
                        bus_data_out <= wdata_q;
                    end
                end
                T2: begin
                    state <= T3;
                end
                T3: begin
`ifdef BCU_WAIT_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    if (bus_ready) begin
                        state     <= T4;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= capture_data;
                    end else begin
                        state <= TW;
                    end
                end
                TW: begin
                    if (bus_ready) begin
                        state     <= T4;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= capture_data;
                    end
`ifdef BCU_WAIT_TIMEOUT_EN
                    else if (wait_expired) begin
                        state     <= T4;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '1;
                        err_q     <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                T4: begin
                    rsp_valid   <= 1'b0;
                    bus_data_oe <= 1'b0;
`ifdef BCU_WAIT_TIMEOUT_EN
                    err_q       <= 1'b0;
`endif
                    if (!accept) begin
                        state     <= IDLE;
                        bus_rd_wr <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // An accept (only possible in IDLE or T4) overrides the state update above.
            if (accept) begin
                state     <= T1;
                op_q      <= req_op;
                wdata_q   <= req_wdata;
                bus_addr  <= phys_addr;
                bus_ale   <= 1'b1;
                bus_rd_wr <= req_op;
            end
        end
    end

endmodule
